// File: rtl/carfield_pll_bringup_seq_pkg.sv
// Shared types and default constants for the PLL bring-up sequencer.
// The optional auto-relock path (CARFIELD_PLL_SEQ_AUTORELOCK_EN) reuses pll_seq_state_e::RELOCK.
package carfield_pll_bringup_seq_pkg;

    typedef enum logic [1:0] {
        ClkHost   = 2'd0,
        ClkPeriph = 2'd1,
        ClkAlt    = 2'd2
    } carfield_clocks_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PLL_ON  = 3'd1,
        STABLE  = 3'd2,
        RELEASE = 3'd3,
        RUN     = 3'd4,
        ERROR   = 3'd5,
        RELOCK  = 3'd6
    } pll_seq_state_e;

    typedef enum logic [1:0] {
        ErrNone     = 2'd0,
        ErrTimeout  = 2'd1,
        ErrLockLost = 2'd2
    } pll_seq_err_e;

    // Sub-phase of the per-domain release timer.
    typedef enum logic [1:0] {
        RelIdle = 2'd0,
        RelGate = 2'd1,
        RelRst  = 2'd2
    } rel_state_e;

    localparam int unsigned NumDomainsDefault        = 3;
    localparam int unsigned LockStableCyclesDefault  = 256;
    localparam int unsigned LockTimeoutCyclesDefault = 65536;
    localparam int unsigned DomainGapCyclesDefault   = 16;

endpackage

// File: rtl/carfield_pll_bringup_seq_if.sv
// Control/status bundle between the bring-up sequencer and its surroundings.
interface carfield_pll_bringup_seq_if #(
    parameter int unsigned NumDomains = 3
);
    logic                  start_i;
    logic                  clear_err_i;
    logic                  pll_lock_i;
    logic                  pll_en_o;
    logic [NumDomains-1:0] clk_en_o;
    logic [NumDomains-1:0] domain_rst_no;
    logic                  busy_o;
    logic                  done_o;
    logic                  err_o;
    logic [1:0]            err_code_o;

    modport slave (
        input  start_i, clear_err_i, pll_lock_i,
        output pll_en_o, clk_en_o, domain_rst_no, busy_o, done_o, err_o, err_code_o
    );

    modport master (
        output start_i, clear_err_i, pll_lock_i,
        input  pll_en_o, clk_en_o, domain_rst_no, busy_o, done_o, err_o, err_code_o
    );
endinterface

// File: rtl/carfield_pll_domain_release.sv
// Per-domain GATE/RST gap timer; emits single-cycle gate/reset/done events.
// A start seen on the done cycle chains straight into the next domain's GATE.
module carfield_pll_domain_release
    import carfield_pll_bringup_seq_pkg::*;
#(
    parameter int unsigned GapCycles = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic clear_i,
    output logic gate_c,
    output logic rst_c,
    output logic done_c
);
    localparam int unsigned GapWidth = (GapCycles > 1) ? $clog2(GapCycles) : 1;
    localparam logic [GapWidth-1:0] GapLast = GapWidth'(GapCycles - 1);

    rel_state_e          state_q, state_d;
    logic [GapWidth-1:0] cnt_q, cnt_d;

    assign done_c = (state_q == RelRst) && (cnt_q == GapLast);
    assign rst_c  = (state_q == RelGate) && (cnt_q == GapLast);
    assign gate_c = start_i && !clear_i && ((state_q == RelIdle) || done_c);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            state_d = RelIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                RelIdle: begin
                    if (start_i) begin
                        state_d = RelGate;
                        cnt_d   = '0;
                    end
                end
                RelGate: begin
                    if (cnt_q == GapLast) begin
                        state_d = RelRst;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + GapWidth'(1);
                    end
                end
                RelRst: begin
                    if (cnt_q == GapLast) begin
                        state_d = start_i ? RelGate : RelIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + GapWidth'(1);
                    end
                end
                default: begin
                    state_d = RelIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RelIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/carfield_pll_bringup_seq.sv
// Power-on clocking sequencer: PLL enable, lock qualification, ordered domain release.
// Define CARFIELD_PLL_SEQ_AUTORELOCK_EN to retry lock loss in RUN up to three times.
module carfield_pll_bringup_seq
    import carfield_pll_bringup_seq_pkg::*;
#(
    parameter int unsigned NumDomains        = NumDomainsDefault,
    parameter int unsigned LockStableCycles  = LockStableCyclesDefault,
    parameter int unsigned LockTimeoutCycles = LockTimeoutCyclesDefault,
    parameter int unsigned DomainGapCycles   = DomainGapCyclesDefault,
    parameter int unsigned CntWidth          = $clog2(LockTimeoutCycles + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    carfield_pll_bringup_seq_if.slave bus
);
    localparam int unsigned StabWidth = $clog2(LockStableCycles + 1);
    localparam int unsigned DomWidth  = (NumDomains > 1) ? $clog2(NumDomains) : 1;
    localparam logic [CntWidth-1:0]  TimeoutLast = CntWidth'(LockTimeoutCycles - 1);
    localparam logic [StabWidth-1:0] StableReach = StabWidth'(LockStableCycles);
    localparam logic [DomWidth-1:0]  DomLast     = DomWidth'(NumDomains - 1);

    pll_seq_state_e        state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [StabWidth-1:0]  stab_q, stab_d;
    logic [DomWidth-1:0]   dom_q, dom_d;
    logic [DomWidth-1:0]   gate_idx_c;
    logic                  pll_en_q, pll_en_d;
    logic [NumDomains-1:0] clk_en_q, clk_en_d;
    logic [NumDomains-1:0] rst_n_q, rst_n_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    pll_seq_err_e          err_code_q, err_code_d;
    logic                  lost_c;
    logic                  rel_start_c, rel_clear_c;
    logic                  rel_gate_c, rel_rst_c, rel_done_c;
`ifdef CARFIELD_PLL_SEQ_AUTORELOCK_EN
    logic [1:0]            retry_q, retry_d;
`endif

    // Release timer runs only while in RELEASE with lock held; stops after the last domain.
    assign rel_start_c = (state_q == RELEASE) && bus.pll_lock_i &&
                         !(rel_done_c && (dom_q == DomLast));
    assign rel_clear_c = (state_q != RELEASE) || !bus.pll_lock_i;
    assign gate_idx_c  = rel_done_c ? (dom_q + DomWidth'(1)) : dom_q;

    carfield_pll_domain_release #(
        .GapCycles (DomainGapCycles)
    ) u_release (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (rel_start_c),
        .clear_i (rel_clear_c),
        .gate_c  (rel_gate_c),
        .rst_c   (rel_rst_c),
        .done_c  (rel_done_c)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stab_d     = stab_q;
        dom_d      = dom_q;
        pll_en_d   = pll_en_q;
        clk_en_d   = clk_en_q;
        rst_n_d    = rst_n_q;
        err_code_d = err_code_q;
        lost_c     = 1'b0;
`ifdef CARFIELD_PLL_SEQ_AUTORELOCK_EN
        retry_d    = retry_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d  = PLL_ON;
                    pll_en_d = 1'b1;
                    cnt_d    = '0;
                    stab_d   = '0;
                    dom_d    = '0;
                end
            end
            PLL_ON: begin
                if (bus.pll_lock_i) begin
                    state_d = STABLE;
                    stab_d  = StabWidth'(1);
                    cnt_d   = cnt_q + CntWidth'(1);
                end else if (cnt_q >= TimeoutLast) begin
                    state_d    = ERROR;
                    err_code_d = ErrTimeout;
                    pll_en_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end
            STABLE: begin
                if (stab_q >= StableReach) begin
                    state_d = RELEASE;
                    dom_d   = '0;
                end else if (cnt_q >= TimeoutLast) begin
                    state_d    = ERROR;
                    err_code_d = ErrTimeout;
                    pll_en_d   = 1'b0;
                end else begin
                    cnt_d  = cnt_q + CntWidth'(1);
                    stab_d = bus.pll_lock_i ? (stab_q + StabWidth'(1)) : '0;
                end
            end
            RELEASE: begin
                if (!bus.pll_lock_i) begin
                    lost_c = 1'b1;
                end else begin
                    if (rel_gate_c) clk_en_d[gate_idx_c] = 1'b1;
                    if (rel_rst_c)  rst_n_d[dom_q]       = 1'b1;
                    if (rel_done_c) begin
                        if (dom_q == DomLast) state_d = RUN;
                        else                  dom_d   = dom_q + DomWidth'(1);
                    end
                end
            end
            RUN: begin
                if (!bus.pll_lock_i) begin
`ifdef CARFIELD_PLL_SEQ_AUTORELOCK_EN
                    if (retry_q != 2'd3) begin
                        state_d  = RELOCK;
                        retry_d  = retry_q + 2'd1;
                        clk_en_d = '0;
                        rst_n_d  = '0;
                    end else begin
                        lost_c = 1'b1;
                    end
`else
                    lost_c = 1'b1;
`endif
                end
            end
            ERROR: begin
                if (bus.clear_err_i) begin
                    state_d    = IDLE;
                    err_code_d = ErrNone;
`ifdef CARFIELD_PLL_SEQ_AUTORELOCK_EN
                    retry_d    = 2'd0;
`endif
                end
            end
`ifdef CARFIELD_PLL_SEQ_AUTORELOCK_EN
            RELOCK: begin
                state_d = STABLE;
                cnt_d   = '0;
                stab_d  = bus.pll_lock_i ? StabWidth'(1) : '0;
                dom_d   = '0;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // Lock loss shuts everything down in one cycle.
        if (lost_c) begin
            state_d    = ERROR;
            err_code_d = ErrLockLost;
            pll_en_d   = 1'b0;
            clk_en_d   = '0;
            rst_n_d    = '0;
        end

        busy_d = (state_d == PLL_ON) || (state_d == STABLE) || (state_d == RELEASE);
        done_d = (state_d == RUN);
        err_d  = (state_d == ERROR);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            stab_q     <= '0;
            dom_q      <= '0;
            pll_en_q   <= 1'b0;
            clk_en_q   <= '0;
            rst_n_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ErrNone;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stab_q     <= stab_d;
            dom_q      <= dom_d;
            pll_en_q   <= pll_en_d;
            clk_en_q   <= clk_en_d;
            rst_n_q    <= rst_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

`ifdef CARFIELD_PLL_SEQ_AUTORELOCK_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) retry_q <= 2'd0;
        else         retry_q <= retry_d;
    end
`endif

    assign bus.pll_en_o      = pll_en_q;
    assign bus.clk_en_o      = clk_en_q;
    assign bus.domain_rst_no = rst_n_q;
    assign bus.busy_o        = busy_q;
    assign bus.done_o        = done_q;
    assign bus.err_o         = err_q;
    assign bus.err_code_o    = err_code_q;

endmodule

// File: tb/tb_carfield_pll_bringup_seq.sv
// Bench for carfield_pll_bringup_seq: timeline model checked every cycle plus literal timing points.
module tb_carfield_pll_bringup_seq;
    import carfield_pll_bringup_seq_pkg::*;

    localparam int N  = 3;
    localparam int LS = 256;
    localparam int TO = 65536;
    localparam int G  = 16;

    localparam int P_IDLE = 0, P_PLL = 1, P_STB = 2, P_REL = 3, P_RUN = 4, P_ERR = 5, P_RLK = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    carfield_pll_bringup_seq_if #(.NumDomains(N)) bus ();

    carfield_pll_bringup_seq #(
        .NumDomains        (N),
        .LockStableCycles  (LS),
        .LockTimeoutCycles (TO),
        .DomainGapCycles   (G)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    // Spec-level model: phase, timeout age, stable count, cycles spent in release.
    int m_ph, m_t, m_sc, m_rt, m_code, m_retry;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph <= P_IDLE; m_t <= 0; m_sc <= 0; m_rt <= 0; m_code <= 0; m_retry <= 0;
        end else begin
            case (m_ph)
                P_IDLE: if (bus.start_i) begin m_ph <= P_PLL; m_t <= 0; end
                P_PLL: begin
                    if (bus.pll_lock_i) begin m_ph <= P_STB; m_sc <= 1; m_t <= m_t + 1; end
                    else if (m_t >= TO - 1) begin m_ph <= P_ERR; m_code <= 1; end
                    else m_t <= m_t + 1;
                end
                P_STB: begin
                    if (m_sc >= LS) begin m_ph <= P_REL; m_rt <= 0; end
                    else if (m_t >= TO - 1) begin m_ph <= P_ERR; m_code <= 1; end
                    else begin m_t <= m_t + 1; m_sc <= bus.pll_lock_i ? m_sc + 1 : 0; end
                end
                P_REL: begin
                    if (!bus.pll_lock_i) begin m_ph <= P_ERR; m_code <= 2; end
                    else if (m_rt + 1 == 1 + 2 * G * N) m_ph <= P_RUN;
                    else m_rt <= m_rt + 1;
                end
                P_RUN: begin
                    if (!bus.pll_lock_i) begin
`ifdef CARFIELD_PLL_SEQ_AUTORELOCK_EN
                        if (m_retry < 3) begin m_ph <= P_RLK; m_retry <= m_retry + 1; end
                        else begin m_ph <= P_ERR; m_code <= 2; end
`else
                        m_ph <= P_ERR; m_code <= 2;
`endif
                    end
                end
                P_ERR: if (bus.clear_err_i) begin m_ph <= P_IDLE; m_code <= 0; m_retry <= 0; end
                P_RLK: begin m_ph <= P_STB; m_t <= 0; m_sc <= bus.pll_lock_i ? 1 : 0; end
                default: m_ph <= P_IDLE;
            endcase
        end
    end

    function automatic logic [N-1:0] exp_clk_en();
        logic [N-1:0] v;
        v = '0;
        for (int d = 0; d < N; d++)
            v[d] = (m_ph == P_RUN) || (m_ph == P_REL && m_rt >= 1 + 2 * G * d);
        return v;
    endfunction

    function automatic logic [N-1:0] exp_rst_n();
        logic [N-1:0] v;
        v = '0;
        for (int d = 0; d < N; d++)
            v[d] = (m_ph == P_RUN) || (m_ph == P_REL && m_rt >= 1 + 2 * G * d + G);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("pll_en",   32'(bus.pll_en_o), 32'(m_ph inside {P_PLL, P_STB, P_REL, P_RUN, P_RLK}));
            check("clk_en",   32'(bus.clk_en_o), 32'(exp_clk_en()));
            check("rst_n",    32'(bus.domain_rst_no), 32'(exp_rst_n()));
            check("busy",     32'(bus.busy_o), 32'(m_ph inside {P_PLL, P_STB, P_REL}));
            check("done",     32'(bus.done_o), 32'(m_ph == P_RUN));
            check("err",      32'(bus.err_o), 32'(m_ph == P_ERR));
            check("err_code", 32'(bus.err_code_o), 32'(m_code));
        end
    end

    function automatic logic sig(input int sel);
        case (sel)
            0: return bus.pll_en_o;
            1: return bus.clk_en_o[0];
            2: return bus.domain_rst_no[0];
            3: return bus.clk_en_o[1];
            4: return bus.domain_rst_no[1];
            5: return bus.domain_rst_no[2];
            6: return bus.done_o;
            7: return bus.err_o;
            default: return 1'b0;
        endcase
    endfunction

    // Returns the cycle at which the selected output is first seen high.
    task automatic wait_sig(input string name, input int sel, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sig(sel) === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_all_low(input string tag, input logic pll_exp);
        check({tag, "_pll_en"}, 32'(bus.pll_en_o), 32'(pll_exp));
        check({tag, "_clk_en"}, 32'(bus.clk_en_o), 32'd0);
        check({tag, "_rst_n"},  32'(bus.domain_rst_no), 32'd0);
    endtask

    initial begin
        int p, l, at, k;
        bus.start_i = 1'b0; bus.clear_err_i = 1'b0; bus.pll_lock_i = 1'b0;
        repeat (3) @(negedge clk);
        check_all_low("reset", 1'b0);
        check("reset_busy", 32'(bus.busy_o), 32'd0);
        check("reset_done", 32'(bus.done_o), 32'd0);
        check("reset_err",  32'(bus.err_o), 32'd0);
        check("reset_code", 32'(bus.err_code_o), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal bring-up with lock 100 cycles after PLL enable.
        bus.start_i = 1'b1;
        wait_sig("pll_on", 0, 10, p);
        bus.start_i = 1'b0;
        repeat (99) @(negedge clk);
        bus.pll_lock_i = 1'b1;
        l = cyc + 1;
        check("lock_at_100", 32'(l - p), 32'd100);
        wait_sig("clk_en0", 1, 1000, at); check("clk_en0_at", 32'(at), 32'(l + 257));
        wait_sig("rst0",    2, 100,  at); check("rst0_at",    32'(at), 32'(l + 273));
        wait_sig("clk_en1", 3, 100,  at); check("clk_en1_at", 32'(at), 32'(l + 289));
        wait_sig("rst1",    4, 100,  at); check("rst1_at",    32'(at), 32'(l + 305));
        wait_sig("rst2",    5, 100,  at); check("rst2_at",    32'(at), 32'(l + 337));
        wait_sig("done",    6, 100,  at); check("done_at",    32'(at), 32'(l + 353));

        // Lock loss in RUN.
`ifdef CARFIELD_PLL_SEQ_AUTORELOCK_EN
        for (int r = 0; r < 4; r++) begin
            bus.pll_lock_i = 1'b0;
            @(negedge clk);
            if (r < 3) begin
                check_all_low("relock", 1'b1);
                check("relock_err", 32'(bus.err_o), 32'd0);
                bus.pll_lock_i = 1'b1;
                wait_sig("relock_done", 6, 1000, at);
            end else begin
                check_all_low("lost4", 1'b0);
                check("lost4_err",  32'(bus.err_o), 32'd1);
                check("lost4_code", 32'(bus.err_code_o), 32'd2);
            end
        end
`else
        bus.pll_lock_i = 1'b0;
        @(negedge clk);
        check_all_low("lost", 1'b0);
        check("lost_err",  32'(bus.err_o), 32'd1);
        check("lost_code", 32'(bus.err_code_o), 32'd2);
`endif
        bus.pll_lock_i = 1'b1;
        bus.clear_err_i = 1'b1;
        @(negedge clk);
        bus.clear_err_i = 1'b0;
        bus.pll_lock_i = 1'b0;
        check("clr_err",  32'(bus.err_o), 32'd0);
        check("clr_code", 32'(bus.err_code_o), 32'd0);
        check("clr_busy", 32'(bus.busy_o), 32'd0);

        // Lock glitch at stable count 200 shifts the release by 201 cycles.
        @(negedge clk);
        bus.start_i = 1'b1;
        wait_sig("pll_on2", 0, 10, p);
        bus.start_i = 1'b0;
        repeat (99) @(negedge clk);
        bus.pll_lock_i = 1'b1;
        l = cyc + 1;
        repeat (200) @(negedge clk);
        bus.pll_lock_i = 1'b0;
        @(negedge clk);
        bus.pll_lock_i = 1'b1;
        wait_sig("glitch_clk_en0", 1, 1000, at);
        check("glitch_clk_en0_at", 32'(at), 32'(l + 257 + 201));
        check("glitch_no_err", 32'(bus.err_o), 32'd0);

        // Asynchronous reset in the middle of domain 1.
        wait_sig("clk_en1_b", 3, 100, at);
        #2 rst_n = 1'b0;
        #1;
        check_all_low("async_rst", 1'b0);
        check("async_rst_busy", 32'(bus.busy_o), 32'd0);
        check("async_rst_done", 32'(bus.done_o), 32'd0);
        bus.pll_lock_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_all_low("post_rst", 1'b0);
        check("post_rst_busy", 32'(bus.busy_o), 32'd0);

        // Lock timeout.
        bus.start_i = 1'b1;
        wait_sig("pll_on3", 0, 10, p);
        bus.start_i = 1'b0;
        wait_sig("timeout_err", 7, 70000, at);
        check("timeout_at",   32'(at - p), 32'd65536);
        check("timeout_code", 32'(bus.err_code_o), 32'd1);
        check("timeout_pll",  32'(bus.pll_en_o), 32'd0);
        bus.clear_err_i = 1'b1;
        @(negedge clk);
        bus.clear_err_i = 1'b0;
        check("to_clr_err",  32'(bus.err_o), 32'd0);
        check("to_clr_code", 32'(bus.err_code_o), 32'd0);

        // start_i held through ERROR: PLL_ON comes back two cycles after the clear.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.pll_lock_i = 1'b1;
        wait_sig("hold_clk_en0", 1, 1000, at);
        bus.pll_lock_i = 1'b0;
        @(negedge clk);
        check("rel_lost_code", 32'(bus.err_code_o), 32'd2);
        check_all_low("rel_lost", 1'b0);
        bus.clear_err_i = 1'b1;
        k = cyc;
        @(negedge clk);
        bus.clear_err_i = 1'b0;
        wait_sig("restart", 0, 10, at);
        check("restart_at", 32'(at), 32'(k + 2));
        repeat (5) @(negedge clk);
        bus.start_i = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog at cycle %0d: got no end, expected summary", cyc);
        $fatal(1);
    end

endmodule

// File: doc/carfield_pll_bringup_seq.md
Name: carfield_pll_bringup_seq

Overview:
- Power-on clocking sequencer that runs on the free-running reference clock.
- Enables the chip PLL and waits for a stable lock, with a timeout.
- Then releases each clock domain in `carfield_clocks_e` index order: Host (0), Periph (1), Alt (2). For each domain it first ungates the clock, then deasserts that domain's reset.
- Sits directly upstream of the domain clock gates and reset synchronizers that the chip-level clock indices select. It also monitors for lock loss during operation.

Parameters:
- NumDomains, 3, number of clock domains; index i matches `carfield_clocks_e`.
- LockStableCycles, 256, consecutive cycles of lock high required before any domain is released; must be ≥ 1.
- LockTimeoutCycles, 65536, cycles allowed from PLL enable until stable lock; must be > LockStableCycles.
- DomainGapCycles, 16, wait cycles after ungating a clock and after releasing a reset; must be ≥ 1.
- CntWidth, $clog2(LockTimeoutCycles+1), derived width of the shared counter; not to be overridden.

Ports:
- clk_i, in, 1, reference clock.
- rst_ni, in, 1, asynchronous active-low reset.
- start_i, in, 1, level request to start bring-up; sampled in IDLE only.
- clear_err_i, in, 1, single-cycle pulse that clears ERROR.
- pll_lock_i, in, 1, PLL lock, already two-flop synchronized to clk_i outside this block.
- pll_en_o, out, 1, PLL enable.
- clk_en_o, out, NumDomains, per-domain clock-gate enable.
- domain_rst_no, out, NumDomains, per-domain active-low reset request.
- busy_o, out, 1, high in PLL_ON, STABLE and RELEASE.
- done_o, out, 1, high in RUN only.
- err_o, out, 1, high in ERROR only.
- err_code_o, out, 2, 0 = none, 1 = lock timeout, 2 = lock lost in RUN; sticky until cleared.

Behaviour:
- All outputs are registered.
- Reset values: pll_en_o=0, clk_en_o=0, domain_rst_no=0 (all domains held in reset), busy_o=0, done_o=0, err_o=0, err_code_o=0, FSM in IDLE, counters 0.
- IDLE: if start_i=1, go to PLL_ON next cycle, set pll_en_o=1, clear the counter.
- PLL_ON:
  - The counter increments every cycle.
  - If pll_lock_i=1, go to STABLE with the stable count loaded as 1.
  - If the counter reaches LockTimeoutCycles-1 with no lock, go to ERROR with code 1.
  - If lock and timeout occur in the same cycle, lock wins.
- STABLE:
  - The stable count increments while pll_lock_i=1.
  - A lock drop resets the stable count to 0 and stays in STABLE. The timeout counter keeps running.
  - When the stable count reaches LockStableCycles, go to RELEASE with domain index d=0.
  - If stable-reach and timeout occur in the same cycle, stable-reach wins.
- RELEASE, per domain d:
  - Sub-step GATE: set clk_en_o[d]=1, then wait DomainGapCycles.
  - Sub-step RST: set domain_rst_no[d]=1, then wait DomainGapCycles.
  - Then d increments. After d=NumDomains-1 completes, go to RUN.
  - First-cycle latency: clk_en_o[0] rises 1 cycle after entry into RELEASE. domain_rst_no[0] rises DomainGapCycles cycles after clk_en_o[0].
- Lock loss during RELEASE or RUN (pll_lock_i=0 for 1 cycle):
  - Next cycle: all clk_en_o=0, all domain_rst_no=0, pll_en_o=0, enter ERROR with code 2.
  - Behaviour under the optional feature differs; see below.
- RUN: done_o=1; all enables and resets released. start_i is ignored.
- ERROR:
  - err_o=1, pll_en_o=0, all domains gated and held in reset.
  - clear_err_i=1 → IDLE next cycle, err_code_o=0.
  - If start_i is still high, the sequence restarts one cycle later.
- clear_err_i outside ERROR is ignored.
- Asynchronous reset at any point returns all state to reset values immediately.

Optional Feature:
- Macro: CARFIELD_PLL_SEQ_AUTORELOCK_EN.
- Defined:
  - Lock loss in RUN goes to RELOCK instead of ERROR.
  - On entering RELOCK: all clk_en_o drop and all domain_rst_no drop in the same cycle; pll_en_o stays 1.
  - Re-enter STABLE with a fresh timeout and repeat the full release.
  - A retry counter (2 bits, saturating) increments on each relock. A 4th lock loss in RUN goes to ERROR with code 2. The retry counter clears on reset or clear_err_i.
- Undefined: behaviour is exactly as in Behaviour; no RELOCK state exists.

Decomposition:
- Add to `carfield_chip_pkg`:
  - `pll_seq_state_e` (IDLE, PLL_ON, STABLE, RELEASE, RUN, ERROR, RELOCK).
  - `pll_seq_err_e` (ErrNone=0, ErrTimeout=1, ErrLockLost=2).
  - Default constants for LockStableCycles, LockTimeoutCycles and DomainGapCycles.
- Sub-module: `carfield_pll_domain_release`, a per-domain GATE/RST gap timer with a start/done handshake. One instance is reused, indexed by d.

Test Plan:
- Defaults; start_i=1; lock rises at cycle 100 and stays high → clk_en_o[0] rises at lock+256+1. Domain resets release in order 0, 1, 2, each spaced 16 cycles after its clock enable. done_o=1 after 3×32 release cycles.
- Lock never rises → at cycle 65536 after pll_en_o: err_o=1, err_code_o=1, pll_en_o=0. A clear_err_i pulse returns the FSM to IDLE.
- Lock glitches low once at stable count 200 → stable count restarts from 0; the release point shifts by 201 cycles; no error.
- In RUN, lock drops for 1 cycle:
  - Macro undefined: the next cycle has all clk_en_o=0, all domain_rst_no=0, err_code_o=2.
  - Macro defined: the sequencer enters RELOCK and re-runs the release; the 4th lock loss goes to ERROR.
- Assert rst_ni low mid-RELEASE with d=1 → all outputs are at reset values asynchronously; after reset, IDLE.
- start_i held high through ERROR → after clear_err_i, PLL_ON is re-entered 2 cycles later.
